// File: rtl/wfg_drive_spi_mc_wishbone_reg.sv
// Wishbone register bank for NUM_CH SPI drive channels: CTRL/CFG/CLKCFG/STATUS per channel.
// Define WFG_DRIVE_SPI_MC_SHADOW_EN to stage CFG/CLKCFG in shadow registers committed when idle.
module wfg_drive_spi_mc_wishbone_reg #(
    parameter int unsigned BUSW   = 32,
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DIVW   = 8
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_n_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_we_i,
    input  logic [BUSW/8-1:0]        wbs_sel_i,
    input  logic [BUSW-1:0]          wbs_dat_i,
    input  logic [BUSW-1:0]          wbs_adr_i,
    output logic                     wbs_ack_o,
    output logic                     wbs_err_o,
    output logic [BUSW-1:0]          wbs_dat_o,
    output logic [NUM_CH-1:0]        ctrl_en_q_o,
    output logic [NUM_CH-1:0]        cfg_cpol_q_o,
    output logic [NUM_CH-1:0]        cfg_lsbfirst_q_o,
    output logic [NUM_CH-1:0]        cfg_sspol_q_o,
    output logic [2*NUM_CH-1:0]      cfg_dff_q_o,
    output logic [DIVW*NUM_CH-1:0]   clkcfg_div_q_o,
    input  logic [NUM_CH-1:0]        busy_i,
    input  logic [NUM_CH-1:0]        done_i,
    output logic [NUM_CH-1:0]        irq_o
);

    localparam int unsigned SELW = BUSW / 8;
    localparam int unsigned CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CFGW = 5;

    logic              req;
    logic              adr_ok;
    logic              wr;
    logic              rd;
    logic [1:0]        reg_sel;
    logic [CHW-1:0]    ch_sel;
    logic [BUSW-1:0]   bmask;
    logic [BUSW-1:0]   wdat;
    logic [BUSW-1:0]   rdata;

    logic [NUM_CH-1:0] ie_q;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [NUM_CH-1:0] pend_q;

    logic [NUM_CH-1:0] hit_ctrl;
    logic [NUM_CH-1:0] hit_cfg;
    logic [NUM_CH-1:0] hit_div;
    logic [NUM_CH-1:0] hit_stat;
    logic [NUM_CH-1:0] clr_done;
    logic [NUM_CH-1:0] clr_ovf;

    logic [CFGW-1:0]   cfg_act  [NUM_CH];
    logic [CFGW-1:0]   cfg_view [NUM_CH];
    logic [DIVW-1:0]   div_view [NUM_CH];
    logic [CFGW-1:0]   cfg_new  [NUM_CH];
    logic [DIVW-1:0]   div_new  [NUM_CH];

    logic              unused_bits;

    // Access decode: a new access is taken only when no response is in flight
    assign req     = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & ~wbs_err_o;
    assign adr_ok  = (wbs_adr_i[1:0] == 2'b00) &&
                     (wbs_adr_i[BUSW-1:4] < (BUSW-4)'(NUM_CH));
    assign wr      = req & adr_ok & wbs_we_i;
    assign rd      = req & adr_ok & ~wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];
    assign ch_sel  = wbs_adr_i[CHW+3:4];
    assign wdat    = wbs_dat_i & bmask;

    assign unused_bits = ^{bmask, wdat};

    always_comb begin
        bmask = '0;
        for (int k = 0; k < int'(SELW); k++) begin
            bmask[8*k +: 8] = {8{wbs_sel_i[k]}};
        end
    end

    always_comb begin
        hit_ctrl = '0;
        hit_cfg  = '0;
        hit_div  = '0;
        hit_stat = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (wr && (ch_sel == CHW'(c))) begin
                case (reg_sel)
                    2'd0:    hit_ctrl[c] = 1'b1;
                    2'd1:    hit_cfg[c]  = 1'b1;
                    2'd2:    hit_div[c]  = 1'b1;
                    default: hit_stat[c] = 1'b1;
                endcase
            end
        end
    end

    assign clr_done = hit_stat & {NUM_CH{wdat[1]}};
    assign clr_ovf  = hit_stat & {NUM_CH{wdat[2]}};

`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
    logic [CFGW-1:0]   sh_cfg_q [NUM_CH];
    logic [DIVW-1:0]   sh_div_q [NUM_CH];
    logic [NUM_CH-1:0] commit;

    assign commit = hit_ctrl & {NUM_CH{wdat[1]}};

    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cfg_view[c] = sh_cfg_q[c];
            div_view[c] = sh_div_q[c];
        end
    end
`else
    assign pend_q = '0;

    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cfg_view[c] = cfg_act[c];
            div_view[c] = clkcfg_div_q_o[DIVW*c +: DIVW];
        end
    end
`endif

    // Byte-lane merge of write data into whichever copy the bus sees
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cfg_act[c] = {cfg_sspol_q_o[c], cfg_dff_q_o[2*c +: 2],
                          cfg_lsbfirst_q_o[c], cfg_cpol_q_o[c]};
            cfg_new[c] = (cfg_view[c] & ~bmask[CFGW-1:0]) | wdat[CFGW-1:0];
            div_new[c] = (div_view[c] & ~bmask[DIVW-1:0]) | wdat[DIVW-1:0];
        end
    end

    // Read mux; sampled before any same-cycle status update lands
    always_comb begin
        rdata = '0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (ch_sel == CHW'(c)) begin
                case (reg_sel)
                    2'd0:    rdata[2:0]      = {ie_q[c], 1'b0, ctrl_en_q_o[c]};
                    2'd1:    rdata[CFGW-1:0] = cfg_view[c];
                    2'd2:    rdata[DIVW-1:0] = div_view[c];
                    default: rdata[3:0]      = {pend_q[c], ovf_q[c], done_q[c], busy_i[c]};
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= req & adr_ok;
            wbs_err_o <= req & ~adr_ok;
            if (req && !adr_ok) begin
                wbs_dat_o <= '0;
            end else if (rd) begin
                wbs_dat_o <= rdata;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            ctrl_en_q_o      <= '0;
            ie_q             <= '0;
            done_q           <= '0;
            ovf_q            <= '0;
            irq_o            <= '0;
            cfg_cpol_q_o     <= '0;
            cfg_lsbfirst_q_o <= '0;
            cfg_sspol_q_o    <= '0;
            cfg_dff_q_o      <= '0;
            clkcfg_div_q_o   <= '0;
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
            pend_q           <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                sh_cfg_q[c] <= '0;
                sh_div_q[c] <= '0;
            end
`endif
        end else begin
            irq_o  <= done_q & ie_q;
            // A new done while DONE is being acknowledged is not an overflow
            done_q <= (done_q & ~clr_done) | done_i;
            ovf_q  <= (ovf_q & ~clr_ovf) | (done_i & done_q & ~clr_done);
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (hit_ctrl[c] && bmask[0]) begin
                    ctrl_en_q_o[c] <= wdat[0];
                    ie_q[c]        <= wdat[2];
                end
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
                if (hit_cfg[c]) begin
                    sh_cfg_q[c] <= cfg_new[c];
                end
                if (hit_div[c]) begin
                    sh_div_q[c] <= div_new[c];
                end
                if (pend_q[c] && !busy_i[c]) begin
                    {cfg_sspol_q_o[c], cfg_dff_q_o[2*c +: 2],
                     cfg_lsbfirst_q_o[c], cfg_cpol_q_o[c]} <= sh_cfg_q[c];
                    clkcfg_div_q_o[DIVW*c +: DIVW]        <= sh_div_q[c];
                end
`else
                if (hit_cfg[c]) begin
                    {cfg_sspol_q_o[c], cfg_dff_q_o[2*c +: 2],
                     cfg_lsbfirst_q_o[c], cfg_cpol_q_o[c]} <= cfg_new[c];
                end
                if (hit_div[c]) begin
                    clkcfg_div_q_o[DIVW*c +: DIVW] <= div_new[c];
                end
`endif
            end
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
            pend_q <= (pend_q & busy_i) | commit;
`endif
        end
    end

endmodule

// File: tb/tb_wfg_drive_spi_mc_wishbone_reg.sv
// Bench for wfg_drive_spi_mc_wishbone_reg: register-image model checked every cycle plus directed literals.
module tb_wfg_drive_spi_mc_wishbone_reg;

    localparam int unsigned BUSW   = 32;
    localparam int unsigned NUM_CH = 2;
    localparam int unsigned DIVW   = 8;
    localparam logic [31:0] DIV_MASK = (32'd1 << DIVW) - 32'd1;

    logic                   wb_clk_i;
    logic                   wb_rst_n_i;
    logic                   wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]             wbs_sel_i;
    logic [31:0]            wbs_dat_i, wbs_adr_i;
    logic                   wbs_ack_o, wbs_err_o;
    logic [31:0]            wbs_dat_o;
    logic [NUM_CH-1:0]      ctrl_en_q_o, cfg_cpol_q_o, cfg_lsbfirst_q_o, cfg_sspol_q_o;
    logic [2*NUM_CH-1:0]    cfg_dff_q_o;
    logic [DIVW*NUM_CH-1:0] clkcfg_div_q_o;
    logic [NUM_CH-1:0]      busy_i, done_i, irq_o;

    wfg_drive_spi_mc_wishbone_reg #(.BUSW(BUSW), .NUM_CH(NUM_CH), .DIVW(DIVW)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_dat_o(wbs_dat_o),
        .ctrl_en_q_o(ctrl_en_q_o), .cfg_cpol_q_o(cfg_cpol_q_o),
        .cfg_lsbfirst_q_o(cfg_lsbfirst_q_o), .cfg_sspol_q_o(cfg_sspol_q_o),
        .cfg_dff_q_o(cfg_dff_q_o), .clkcfg_div_q_o(clkcfg_div_q_o),
        .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one 32-bit image per register, written through lane and writable-bit masks
    logic [31:0]       m_ctrl [NUM_CH];
    logic [31:0]       m_cfg_act [NUM_CH];
    logic [31:0]       m_div_act [NUM_CH];
    logic [31:0]       m_cfg_sh [NUM_CH];
    logic [31:0]       m_div_sh [NUM_CH];
    logic [NUM_CH-1:0] m_done, m_ovf, m_pend, m_irq;
    logic              m_ack, m_err;
    logic [31:0]       m_dat;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [31:0] bm, input logic [31:0] wm);
        return (old & ~(bm & wm)) | (d & bm & wm);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    function automatic logic [31:0] read_word(input int ch, input int rg);
        case (rg)
            0: return m_ctrl[ch] & 32'h5;
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
            1: return m_cfg_sh[ch];
            2: return m_div_sh[ch];
`else
            1: return m_cfg_act[ch];
            2: return m_div_act[ch];
`endif
            default: return {28'd0, m_pend[ch], m_ovf[ch], m_done[ch], busy_i[ch]};
        endcase
    endfunction

    always @(posedge wb_clk_i) begin : model
        logic acc, ok, wr;
        int ch, rg;
        logic [31:0] bm, d;
        logic [NUM_CH-1:0] cd, co, old_done;
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
        logic [NUM_CH-1:0] cm;
`endif
        if (!wb_rst_n_i) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                m_ctrl[c] = '0; m_cfg_act[c] = '0; m_div_act[c] = '0;
                m_cfg_sh[c] = '0; m_div_sh[c] = '0;
            end
            m_done = '0; m_ovf = '0; m_pend = '0; m_irq = '0;
            m_ack = 1'b0; m_err = 1'b0; m_dat = '0;
        end else begin
            acc = wbs_stb_i && wbs_cyc_i && !m_ack && !m_err;
            ok  = (wbs_adr_i[1:0] == 2'b00) && ((wbs_adr_i >> 4) < 32'(NUM_CH));
            ch  = int'(wbs_adr_i[6:4]);
            rg  = int'(wbs_adr_i[3:2]);
            bm  = lane_mask(wbs_sel_i);
            d   = wbs_dat_i & bm;
            wr  = acc && ok && wbs_we_i;
            if (acc && !ok) m_dat = '0;
            else if (acc && !wbs_we_i) m_dat = read_word(ch, rg);
            for (int c = 0; c < int'(NUM_CH); c++) m_irq[c] = m_done[c] & m_ctrl[c][2];
            cd = '0; co = '0;
            if (wr && rg == 3) begin cd[ch] = d[1]; co[ch] = d[2]; end
            old_done = m_done;
            m_done = (m_done & ~cd) | done_i;
            m_ovf  = (m_ovf & ~co) | (done_i & old_done & ~cd);
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
            cm = '0;
            if (wr && rg == 0) cm[ch] = d[1];
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (m_pend[c] && !busy_i[c]) begin
                    m_cfg_act[c] = m_cfg_sh[c];
                    m_div_act[c] = m_div_sh[c];
                    m_pend[c]    = 1'b0;
                end
            end
            m_pend = m_pend | cm;
`endif
            if (wr) begin
                case (rg)
                    0: m_ctrl[ch] = merge(m_ctrl[ch], d, bm, 32'h5);
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
                    1: m_cfg_sh[ch] = merge(m_cfg_sh[ch], d, bm, 32'h1F);
                    2: m_div_sh[ch] = merge(m_div_sh[ch], d, bm, DIV_MASK);
`else
                    1: m_cfg_act[ch] = merge(m_cfg_act[ch], d, bm, 32'h1F);
                    2: m_div_act[ch] = merge(m_div_act[ch], d, bm, DIV_MASK);
`endif
                    default: ;
                endcase
            end
            m_ack = acc && ok;
            m_err = acc && !ok;
        end
    end

    // Every-cycle comparison of all registered outputs against the model
    always @(negedge wb_clk_i) begin : compare
        logic [NUM_CH-1:0]      e_en, e_cpol, e_lsb, e_ss;
        logic [2*NUM_CH-1:0]    e_dff;
        logic [DIVW*NUM_CH-1:0] e_div;
        if (chk_en) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                e_en[c]             = m_ctrl[c][0];
                e_cpol[c]           = m_cfg_act[c][0];
                e_lsb[c]            = m_cfg_act[c][1];
                e_dff[2*c +: 2]     = m_cfg_act[c][3:2];
                e_ss[c]             = m_cfg_act[c][4];
                e_div[DIVW*c +: DIVW] = m_div_act[c][DIVW-1:0];
            end
            check("cyc_ack",   32'(wbs_ack_o), 32'(m_ack));
            check("cyc_err",   32'(wbs_err_o), 32'(m_err));
            check("cyc_both",  32'(wbs_ack_o & wbs_err_o), 32'd0);
            check("cyc_dat",   wbs_dat_o, m_dat);
            check("cyc_irq",   32'(irq_o), 32'(m_irq));
            check("cyc_en",    32'(ctrl_en_q_o), 32'(e_en));
            check("cyc_cpol",  32'(cfg_cpol_q_o), 32'(e_cpol));
            check("cyc_lsb",   32'(cfg_lsbfirst_q_o), 32'(e_lsb));
            check("cyc_sspol", 32'(cfg_sspol_q_o), 32'(e_ss));
            check("cyc_dff",   32'(cfg_dff_q_o), 32'(e_dff));
            check("cyc_div",   32'(clkcfg_div_q_o), 32'(e_div));
        end
    end

    task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [NUM_CH-1:0] dn,
                       output logic ack, output logic err, output logic [31:0] rdat);
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; done_i = dn;
        @(posedge wb_clk_i); #1;
        ack = wbs_ack_o; err = wbs_err_o; rdat = wbs_dat_o;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0; done_i = '0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic wr(input string nm, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [NUM_CH-1:0] dn);
        logic a, e;
        logic [31:0] r;
        bus(1'b1, adr, dat, sel, dn, a, e, r);
        check({nm, "_ack"}, 32'(a), 32'd1);
    endtask

    task automatic rd(input string nm, input logic [31:0] adr, input logic [31:0] exp);
        logic a, e;
        logic [31:0] r;
        bus(1'b0, adr, 32'd0, 4'hF, '0, a, e, r);
        check({nm, "_ack"}, 32'(a), 32'd1);
        check({nm, "_dat"}, r, exp);
    endtask

    task automatic pulse_done(input logic [NUM_CH-1:0] d);
        done_i = d;
        @(posedge wb_clk_i); #1;
        done_i = '0;
    endtask

    initial begin
        logic a, e;
        logic [31:0] r;
        wb_rst_n_i = 1'b0;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
        busy_i = '0; done_i = '0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        chk_en = 1'b1;
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_err", 32'(wbs_err_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_irq", 32'(irq_o), 32'd0);
        check("rst_en",  32'(ctrl_en_q_o), 32'd0);
        check("rst_cfg", 32'({cfg_cpol_q_o, cfg_lsbfirst_q_o, cfg_sspol_q_o, cfg_dff_q_o}), 32'd0);
        check("rst_div", 32'(clkcfg_div_q_o), 32'd0);
        wb_rst_n_i = 1'b1;

        rd("rd14", 32'h14, 32'h0);
        rd("rd1c", 32'h1C, 32'h0);

        // Byte lanes on channel 1 CLKCFG
        wr("bl1", 32'h18, 32'h0000_00AB, 4'b0001, '0);
`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
        check("bl1_div", 32'(clkcfg_div_q_o), 32'h0);
`else
        check("bl1_div", 32'(clkcfg_div_q_o[15:8]), 32'hAB);
`endif
        wr("bl2", 32'h18, 32'h0000_FF00, 4'b0010, '0);
`ifndef WFG_DRIVE_SPI_MC_SHADOW_EN
        check("bl2_div", 32'(clkcfg_div_q_o[15:8]), 32'hAB);
`endif
        rd("bl_rd", 32'h18, 32'hAB);

        // Unmapped: channel out of range, then misaligned write
        bus(1'b0, 32'h20, 32'd0, 4'hF, '0, a, e, r);
        check("um_rd_err", 32'(e), 32'd1);
        check("um_rd_ack", 32'(a), 32'd0);
        check("um_rd_dat", r, 32'd0);
        bus(1'b1, 32'h06, 32'hFFFF_FFFF, 4'hF, '0, a, e, r);
        check("um_wr_err", 32'(e), 32'd1);
        check("um_wr_ack", 32'(a), 32'd0);
        rd("um_cfg0", 32'h04, 32'h0);
        rd("um_ctrl0", 32'h00, 32'h0);

        // Sticky DONE/OVF and interrupt on channel 0
        wr("ie", 32'h00, 32'h4, 4'hF, '0);
        pulse_done(2'b01);
        check("irq_lat0", 32'(irq_o[0]), 32'd0);
        @(posedge wb_clk_i); #1;
        check("irq_lat1", 32'(irq_o[0]), 32'd1);
        pulse_done(2'b01);
        rd("st_ovf", 32'h0C, 32'h6);
        rd("st_ch1", 32'h1C, 32'h0);
        wr("w1c_set", 32'h0C, 32'h6, 4'hF, 2'b01);
        rd("st_setwin", 32'h0C, 32'h2);
        check("irq_hold", 32'(irq_o[0]), 32'd1);
        wr("w1c_sel0", 32'h0C, 32'h2, 4'b0010, '0);
        rd("st_nosel", 32'h0C, 32'h2);
        wr("w1c_clr", 32'h0C, 32'h2, 4'hF, '0);
        rd("st_clr", 32'h0C, 32'h0);
        check("irq_clr", 32'(irq_o[0]), 32'd0);

`ifdef WFG_DRIVE_SPI_MC_SHADOW_EN
        busy_i = 2'b01;
        wr("sh_cfg", 32'h04, 32'h1D, 4'h1, '0);
        wr("sh_commit", 32'h00, 32'h2, 4'h1, '0);
        check("sh_cpol_busy", 32'(cfg_cpol_q_o[0]), 32'd0);
        rd("sh_pend", 32'h0C, 32'h9);
        rd("sh_rdcfg", 32'h04, 32'h1D);
        busy_i = 2'b00;
        @(posedge wb_clk_i); #1;
        check("sh_cpol", 32'(cfg_cpol_q_o[0]), 32'd1);
        check("sh_lsb",  32'(cfg_lsbfirst_q_o[0]), 32'd0);
        check("sh_dff",  32'(cfg_dff_q_o[1:0]), 32'd3);
        check("sh_ss",   32'(cfg_sspol_q_o[0]), 32'd1);
        rd("sh_pend0", 32'h0C, 32'h0);
        wr("sh_commit1", 32'h10, 32'h2, 4'h1, '0);
        check("sh_div1", 32'(clkcfg_div_q_o), 32'hAB00);
`else
        wr("dp_cfg", 32'h04, 32'h01, 4'hF, '0);
        check("dp_cpol", 32'(cfg_cpol_q_o[0]), 32'd1);
        check("dp_dff",  32'(cfg_dff_q_o), 32'd0);
        wr("dp_commit", 32'h00, 32'h2, 4'hF, '0);
        rd("dp_st", 32'h0C, 32'h0);
        check("dp_cpol2", 32'(cfg_cpol_q_o[0]), 32'd1);
`endif
        wr("en1", 32'h10, 32'h1, 4'hF, '0);
        check("en1", 32'(ctrl_en_q_o), 32'h2);
        rd("en1_rd", 32'h10, 32'h1);

        // Reset landing on an accepting edge loses the access
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = 1'b1;
        wbs_adr_i = 32'h04; wbs_dat_i = 32'h1F; wbs_sel_i = 4'hF;
        wb_rst_n_i = 1'b0;
        @(posedge wb_clk_i); #1;
        check("mr_ack", 32'(wbs_ack_o), 32'd0);
        check("mr_en",  32'(ctrl_en_q_o), 32'd0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        wb_rst_n_i = 1'b1;
        @(posedge wb_clk_i); #1;
        rd("mr_cfg", 32'h04, 32'h0);
        rd("mr_div", 32'h18, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wfg_drive_spi_mc_wishbone_reg.md
# wfg_drive_spi_mc_wishbone_reg

Parametrised multi-channel Wishbone register bank for the SPI drive.
- Provides per-channel CTRL/CFG/CLKCFG/STATUS registers for `NUM_CH` SPI drive channels, with byte-lane write enables and error response on unmapped addresses.
- Sticky write-one-to-clear status bits with interrupt output.
- Optional shadow/commit staging, so configuration never changes under a busy channel.
- Sits between the Wishbone interconnect and `NUM_CH` `wfg_drive_spi` cores.

## Interface
Parameters:
- `BUSW`, 32: Wishbone data/address width; only 32 is supported.
- `NUM_CH`, 2: channel count, 1..8.
- `DIVW`, 8: clock-divider field width, 1..16.

Ports:
- `wb_clk_i` input, 1: single clock.
- `wb_rst_n_i` input, 1: reset, synchronous, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` input, 1 each: Wishbone strobe, cycle, write enable.
- `wbs_sel_i` input, BUSW/8: byte-lane select.
- `wbs_dat_i` input, BUSW: write data.
- `wbs_adr_i` input, BUSW: byte address.
- `wbs_ack_o` output, 1: acknowledge for a mapped access.
- `wbs_err_o` output, 1: error for an unmapped access.
- `wbs_dat_o` output, BUSW: read data.
- `ctrl_en_q_o` output, NUM_CH: per-channel enable.
- `cfg_cpol_q_o`, `cfg_lsbfirst_q_o`, `cfg_sspol_q_o` output, NUM_CH each: active configuration bits.
- `cfg_dff_q_o` output, 2*NUM_CH: frame format; channel c occupies [2c+1:2c].
- `clkcfg_div_q_o` output, DIVW*NUM_CH: divider; channel c occupies [DIVW*c+DIVW-1:DIVW*c].
- `busy_i` input, NUM_CH: channel transfer in progress (level).
- `done_i` input, NUM_CH: one-cycle end-of-transfer pulse.
- `irq_o` output, NUM_CH: per-channel interrupt.

## Operation
Address map:
- Channel c base is `c*0x10`.
- The register is selected by `adr[3:2]`.
- Valid only when `adr[1:0]==0`, `adr[BUSW-1:4] < NUM_CH`, and for writes the register is writable (STATUS is writable; all four are).

Registers:
- **0x0 CTRL**
  - EN[0] rw.
  - COMMIT[1]: write-1 pulse, reads 0.
  - IE[2] rw.
- **0x4 CFG**
  - CPOL[0], LSBFIRST[1], DFF[3:2], SSPOL[4].
- **0x8 CLKCFG**
  - DIV[DIVW-1:0].
- **0xC STATUS**
  - BUSY[0] ro, equals `busy_i[c]`.
  - DONE[1] sticky, W1C.
  - OVF[2] sticky, W1C.
  - PEND[3] ro.

Access rules:
- Writes: only bytes with `wbs_sel_i[k]=1` update fields lying in byte k. Unselected bytes are unchanged.
- Reads: return the full word regardless of `wbs_sel_i`. Undefined bits read 0.

Status:
- DONE sets on `done_i[c]`.
- OVF sets on `done_i[c]` while DONE is already 1.
- If a set and a W1C clear land in the same cycle, set wins.
- `irq_o[c] = DONE & IE`, registered.

## Timing
Access cycle:
- A new access is accepted when `stb & cyc & !ack & !err`.
- `wbs_ack_o` or `wbs_err_o` pulses exactly one cycle later, for one cycle.
- The two are never asserted together, and never on consecutive cycles.
- The register update happens on the same edge that raises ack.
- `wbs_dat_o` is registered and valid in the ack cycle.
- `wbs_dat_o` is 0 in the err cycle and holds its last value otherwise.
- A read returns the value from before any same-cycle `done_i` update.

Reset values (on the edge with `wb_rst_n_i=0`):
- All outputs 0: ack, err, dat, irq, EN, CFG fields, DIV.
- Shadow registers, DONE, OVF and PEND all 0.
- Reset asserted mid-access drops ack/err, and the access is lost.
- `irq_o` follows DONE/IE with one cycle of latency.

## Configuration
Macro `WFG_DRIVE_SPI_MC_SHADOW_EN`.

Defined:
- CFG and CLKCFG writes go to shadow registers. CFG/CLKCFG reads return the shadow.
- Writing COMMIT=1 sets PEND.
- PEND is cleared, and shadow is copied to the active outputs, on the first edge where PEND=1 and `busy_i[c]=0`. With `busy_i=0` this edge comes one cycle after the commit-write ack edge.
- COMMIT while PEND=1 is harmless and keeps PEND set.
- A shadow write while PEND=1 is captured by the pending copy.
- EN is never shadowed.

Undefined:
- No shadow registers. Writes update the active outputs on the ack edge.
- COMMIT is ignored and PEND reads 0.

## Test plan
- **Reset and read-back.** Hold `wb_rst_n_i=0` for 2 cycles, release, then read 0x14 and 0x1C. Required: every output 0; ack exactly 1 cycle after stb; read data 0x0.
- **Byte-lane write.** Write 0x0000_00AB to 0x18 with sel=4'b0001, then 0x0000_FF00 with sel=4'b0010. Required, with DIVW=8: `clkcfg_div_q_o[15:8]=0xAB` after the first write, unchanged after the second.
- **Unmapped access.** With NUM_CH=2, read 0x20 and write 0x06. Required: `wbs_err_o` for 1 cycle, no ack, dat_o 0, no register changes.
- **Sticky status and interrupt.** Set IE on channel 0. Pulse `done_i[0]` twice, then W1C 0x6 to 0x0C in the same cycle as a third pulse. Required: DONE=1 and OVF=1 after the second pulse; `irq_o[0]=1` one cycle after the first pulse; after the W1C, DONE=1 (set wins) and OVF=0.
- **Shadow commit while busy.** With the macro defined, hold `busy_i[0]=1`, write CFG 0x1D, then COMMIT. Required: `cfg_cpol_q_o[0]=0` and PEND=1 while busy. Drop busy; one edge later CPOL=1, LSBFIRST=0, DFF=2'b11, SSPOL=1 and PEND=0.
- **Direct path.** With the macro undefined, write CFG 0x01. Required: `cfg_cpol_q_o[0]=1` on the ack edge; COMMIT has no effect and STATUS[3] reads 0.
